// File: rtl/cmp_arb_pkg.sv
// Shared types and default sizes for the time-shared comparator arbiter.
package cmp_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

endpackage

// File: rtl/cmp_core.sv
// Purely combinational unsigned magnitude comparator shared by all requesters.
module cmp_core
  import cmp_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/cmp_arbiter.sv
// Arbitrates NUM_REQ requesters onto one comparator: latch winner, compare, strobe result.
// Define CMP_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     res_valid,
  output logic [IDW-1:0]           res_id,
  output logic                     res_lt,
  output logic                     res_eq,
  output logic                     res_gt,
  output logic                     busy
);

  state_t           state;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   gnt_id;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH-1:0] a_lat, b_lat;
  logic             core_lt, core_eq, core_gt;
  cmp_res_t         res_q;

`ifdef CMP_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] rr_ptr;

  // Scan offsets from high to low so the requester closest to rr_ptr wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[rr_ptr + IDW'(i)]) grant_idx = rr_ptr + IDW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (state == ST_IDLE && |req) begin
      rr_ptr <= grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) grant_idx = IDW'(i);
    end
  end
`endif

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        a_sel = a_in[i*WIDTH +: WIDTH];
        b_sel = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .a  (a_lat),
    .b  (b_lat),
    .lt (core_lt),
    .eq (core_eq),
    .gt (core_gt)
  );

  // res_id only moves on the CMP edge, so it stays stable alongside the result flags.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_lat  <= '0;
      b_lat  <= '0;
      gnt_id <= '0;
      res_id <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            a_lat  <= a_sel;
            b_lat  <= b_sel;
            gnt_id <= grant_idx;
            state  <= ST_CMP;
          end
        end
        ST_CMP: begin
          res_q  <= '{lt: core_lt, eq: core_eq, gt: core_gt};
          res_id <= gnt_id;
          state  <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (state == ST_DONE) ack[res_id] = 1'b1;
  end

  assign res_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign res_lt    = res_q.lt;
  assign res_eq    = res_q.eq;
  assign res_gt    = res_q.gt;

endmodule
